branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter ENTRIES, default 64, sets the number of BHT entries; SHALL be a power of two, at least 4.
REQ-002 Parameter CTR_W, default 2, sets the saturating-counter width in bits; SHALL be at least 2.
REQ-003 Parameter PC_W, default 32, sets the PC width in bits.
REQ-004 Ports SHALL be:
- clk  in  1  single clock, all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline hazard stall.
- csr_stall  in  1  CSR/trap stall.
- if_stall  in  1  IF stage stalled (fetch outstanding).
- if_pc  in  PC_W  fetch PC used for lookup.
- predict_taken  out  1  prediction for if_pc.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_pc  in  PC_W  PC of the EX instruction.
- is_ex_jump  in  1  actual branch outcome in EX.
- predict_ex_jump  in  1  prediction carried down with the EX instruction.
- b_stall  out  2  redirect kind this cycle: 01 = predicted not-taken but taken, 10 = predicted taken but not taken, 00 = none.
- flush_pending  out  1  a mispredict arrived during if_stall and the flush is still owed.
- pending_kind  out  2  b_stall code latched for the pending flush.
- mispredict_cnt  out  32  mispredict counter; present only with BPU_STATS_EN.

Function
REQ-005 Index SHALL be pc[$clog2(ENTRIES)+1:2] for both lookup and update.
REQ-006 predict_taken SHALL be combinational and equal the MSB of the counter indexed by if_pc.
REQ-007 An update event SHALL be ex_valid & ex_is_branch & ~stall & ~csr_stall.
REQ-008 On an update event, the counter at ex_pc SHALL increment if is_ex_jump=1, saturating at 2^CTR_W-1.
REQ-009 On an update event, the counter at ex_pc SHALL decrement if is_ex_jump=0, saturating at 0.
REQ-010 A lookup and an update to the same index in one cycle SHALL return the pre-update value; no bypass.
REQ-011 b_stall SHALL be combinational, with ex_valid=0 forcing 00:
- 01 when is_ex_jump=1 and predict_ex_jump=0;
- 10 when is_ex_jump=0 and predict_ex_jump=1;
- 00 otherwise.
REQ-012 The recovery FSM SHALL have two states, IDLE and PENDING.
REQ-013 The FSM SHALL go IDLE->PENDING when b_stall!=00 & if_stall & ~stall & ~csr_stall, and latch b_stall into pending_kind.
REQ-014 The FSM SHALL go PENDING->IDLE on the first cycle with if_stall=0, and clear pending_kind to 00.
REQ-015 In PENDING, a new qualifying mispredict SHALL overwrite pending_kind and keep the state PENDING.
REQ-016 If the exit condition (if_stall=0) and a new mispredict coincide, exit SHALL take priority, since a new mispredict cannot qualify without if_stall.
REQ-017 flush_pending SHALL be registered and equal state==PENDING.
REQ-018 While stall or csr_stall is high, the FSM SHALL hold, pending_kind SHALL hold, and the BHT SHALL hold.

Reset
REQ-019 rst SHALL asynchronously return the FSM to IDLE, with flush_pending=0 and pending_kind=00.
REQ-020 rst SHALL set every BHT counter to 2^(CTR_W-1)-1 (weakly not-taken, 01 for CTR_W=2).
REQ-021 rst SHALL clear mispredict_cnt to 0 when BPU_STATS_EN is defined.
REQ-022 Reset asserted mid-PENDING SHALL drop the owed flush with no further output.

Configuration
REQ-023 With BPU_STATS_EN defined, mispredict_cnt SHALL increment by 1 on each cycle with b_stall!=00 & ~stall & ~csr_stall, and wrap from 2^32-1 to 0.
REQ-024 Without BPU_STATS_EN, the mispredict_cnt port and its register SHALL be absent; all other behaviour is unchanged.

Verification
REQ-025 Reset, then if_pc=0x100 -> predict_taken=0; flush_pending=0; b_stall=00.
REQ-026 Three update events at ex_pc=0x100 with is_ex_jump=1 -> predict_taken=1 for if_pc=0x100 after the first event; counter saturates at 3; a fourth taken event leaves it at 3.
REQ-027 ex_valid=1, is_ex_jump=0, predict_ex_jump=1, if_stall=1 -> b_stall=10 the same cycle; flush_pending=1 and pending_kind=10 next cycle; if_stall drops 4 cycles later -> flush_pending=0 on the following edge.
REQ-028 Mispredict 01 with if_stall=1 and stall=1 -> FSM stays IDLE and the BHT is unchanged; repeating with stall=0 -> PENDING with pending_kind=01.
REQ-029 Assert rst asynchronously (between edges) while PENDING -> flush_pending=0 immediately; the counter at 0x100 returns to 01.
REQ-030 With BPU_STATS_EN and ENTRIES=16: five unstalled mispredicts -> mispredict_cnt=5; ex_pc=0x100 and 0x140 alias (index bits [5:2]) and update the same counter.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// Branch predictor bus interface.
// Groups the stall qualifiers, fetch lookup, EX resolution and redirect
// outputs of branch_predict_unit. clk/rst are not part of the bundle.
//   slave  : the predictor side (consumes stalls/PCs, drives prediction,
//            b_stall, flush_pending, pending_kind, mispredict_cnt)
//   master : the pipeline side (drives the inputs, observes the outputs)
// Optional macro BPU_STATS_EN adds the 32-bit mispredict_cnt signal.
interface branch_predict_unit_if #(
  parameter int unsigned PC_W = 32
);
  logic            stall;
  logic            csr_stall;
  logic            if_stall;
  logic [PC_W-1:0] if_pc;
  logic            predict_taken;
  logic            ex_valid;
  logic            ex_is_branch;
  logic [PC_W-1:0] ex_pc;
  logic            is_ex_jump;
  logic            predict_ex_jump;
  logic [1:0]      b_stall;
  logic            flush_pending;
  logic [1:0]      pending_kind;
`ifdef BPU_STATS_EN
  logic [31:0]     mispredict_cnt;
`endif

  modport slave (
    input  stall, csr_stall, if_stall, if_pc,
    input  ex_valid, ex_is_branch, ex_pc, is_ex_jump, predict_ex_jump,
    output predict_taken, b_stall, flush_pending, pending_kind
`ifdef BPU_STATS_EN
    , output mispredict_cnt
`endif
  );

  modport master (
    output stall, csr_stall, if_stall, if_pc,
    output ex_valid, ex_is_branch, ex_pc, is_ex_jump, predict_ex_jump,
    input  predict_taken, b_stall, flush_pending, pending_kind
`ifdef BPU_STATS_EN
    , input mispredict_cnt
`endif
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with mispredict recovery tracking.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - branch_predict_unit_if.slave (lookup, EX update, redirect status)
// A table of ENTRIES saturating counters (CTR_W bits each), indexed by
// pc[$clog2(ENTRIES)+1:2], predicts fetch PCs and is trained by resolved
// conditional branches in EX. A two-state FSM remembers a redirect that
// arrived while fetch was stalled until fetch is free again.
// Optional macro BPU_STATS_EN adds a wrapping 32-bit mispredict counter.
module branch_predict_unit #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned PC_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_predict_unit_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_RST = {1'b0, {(CTR_W-1){1'b1}}};

  typedef enum logic {IDLE, PENDING} state_e;

  state_e           state_q, state_d;
  logic [1:0]       kind_q, kind_d;
  logic [CTR_W-1:0] bht_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic             hold, upd, mis;
  logic [1:0]       b_stall;
  logic [CTR_W-1:0] cur_ctr, nxt_ctr;
  logic             unused_pc;

  assign lk_idx    = bus.if_pc[IDX_W+1:2];
  assign up_idx    = bus.ex_pc[IDX_W+1:2];
  assign unused_pc = ^{bus.if_pc[PC_W-1:IDX_W+2], bus.if_pc[1:0],
                       bus.ex_pc[PC_W-1:IDX_W+2], bus.ex_pc[1:0]};

  assign hold = bus.stall | bus.csr_stall;
  assign upd  = bus.ex_valid & bus.ex_is_branch & ~hold;

  // Lookup reads the registered table, so a same-index update is not seen
  // until the following cycle.
  assign bus.predict_taken = bht_q[lk_idx][CTR_W-1];

  always_comb begin
    b_stall = 2'b00;
    if (bus.ex_valid) begin
      b_stall = {~bus.is_ex_jump & bus.predict_ex_jump,
                  bus.is_ex_jump & ~bus.predict_ex_jump};
    end
  end
  assign bus.b_stall = b_stall;
  assign mis         = (b_stall != 2'b00);

  always_comb begin
    cur_ctr = bht_q[up_idx];
    nxt_ctr = cur_ctr;
    if (bus.is_ex_jump) begin
      if (cur_ctr != '1) nxt_ctr = cur_ctr + 1'b1;
    end else begin
      if (cur_ctr != '0) nxt_ctr = cur_ctr - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) bht_q[i] <= CTR_RST;
    end else if (upd) begin
      bht_q[up_idx] <= nxt_ctr;
    end
  end

  // Recovery FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  // Recovery FSM: next state. Leaving PENDING wins over a new mispredict,
  // which could not qualify anyway once if_stall is low.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    if (!hold) begin
      unique case (state_q)
        IDLE: begin
          if (mis && bus.if_stall) begin
            state_d = PENDING;
            kind_d  = b_stall;
          end
        end
        PENDING: begin
          if (!bus.if_stall) begin
            state_d = IDLE;
            kind_d  = 2'b00;
          end else if (mis) begin
            kind_d  = b_stall;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Recovery FSM: outputs (decoded from registers only)
  always_comb begin
    bus.flush_pending = (state_q == PENDING);
    bus.pending_kind  = kind_q;
  end

`ifdef BPU_STATS_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt_q <= '0;
    else if (mis && !hold) cnt_q <= cnt_q + 32'd1;
  end
  assign bus.mispredict_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
  localparam int unsigned ENT = 16;
  localparam int unsigned CW  = 2;
  localparam int unsigned CMAX = (1 << CW) - 1;
  localparam int unsigned CRST = (1 << (CW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_W(32)) bus ();
  branch_predict_unit #(.ENTRIES(ENT), .CTR_W(CW), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          pt;
    bit [1:0]    bs;
    bit          fp;
    bit [1:0]    pk;
    int unsigned cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: plain counters per table slot plus owed-flush flags
  int unsigned m_ctr [ENT];
  bit          m_pend;
  bit [1:0]    m_kind;
  int unsigned m_cnt;

  function automatic int unsigned slot(logic [31:0] pc);
    return (pc / 4) % ENT;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) m_ctr[i] = CRST;
    m_pend = 0;
    m_kind = 2'b00;
    m_cnt  = 0;
  endtask

  task automatic chk(string name, int unsigned act, int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every unreset cycle; compare at negedge
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("predict_taken", bus.predict_taken, e.pt);
      chk("b_stall", bus.b_stall, e.bs);
      chk("flush_pending", bus.flush_pending, e.fp);
      chk("pending_kind", bus.pending_kind, e.pk);
`ifdef BPU_STATS_EN
      chk("mispredict_cnt", bus.mispredict_cnt, e.cnt);
`endif
    end
  end

  task automatic drive_idle();
    bus.stall = 0; bus.csr_stall = 0; bus.if_stall = 0; bus.if_pc = '0;
    bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_pc = '0;
    bus.is_ex_jump = 0; bus.predict_ex_jump = 0;
  endtask

  task automatic step(bit st, bit cs, bit ifs, logic [31:0] ifpc, bit exv,
                      bit exb, logic [31:0] expc, bit jmp, bit pj);
    exp_t e;
    bit [1:0] bs;
    @(posedge clk);
    #1;
    bus.stall = st; bus.csr_stall = cs; bus.if_stall = ifs; bus.if_pc = ifpc;
    bus.ex_valid = exv; bus.ex_is_branch = exb; bus.ex_pc = expc;
    bus.is_ex_jump = jmp; bus.predict_ex_jump = pj;
    bs = 2'b00;
    if (exv && jmp && !pj) bs = 2'b01;
    if (exv && !jmp && pj) bs = 2'b10;
    e.pt  = (m_ctr[slot(ifpc)] > CRST);
    e.bs  = bs;
    e.fp  = m_pend;
    e.pk  = m_kind;
    e.cnt = m_cnt;
    q.push_back(e);
    // Effects of the coming edge
    if (!(st || cs)) begin
      if (exv && exb) begin
        if (jmp) m_ctr[slot(expc)] = (m_ctr[slot(expc)] == CMAX) ? CMAX : m_ctr[slot(expc)] + 1;
        else     m_ctr[slot(expc)] = (m_ctr[slot(expc)] == 0) ? 0 : m_ctr[slot(expc)] - 1;
      end
      if (m_pend) begin
        if (!ifs) begin
          m_pend = 0; m_kind = 2'b00;
        end else if (bs != 2'b00) begin
          m_kind = bs;
        end
      end else if (bs != 2'b00 && ifs) begin
        m_pend = 1; m_kind = bs;
      end
      if (bs != 2'b00) m_cnt++;
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state lookup
    step(0,0,0, 32'h100, 0,0,32'h0, 0,0);
    // Train 0x100 taken four times (saturation), then two not-taken
    for (int i = 0; i < 4; i++) step(0,0,0, 32'h100, 1,1,32'h100, 1,1);
    for (int i = 0; i < 2; i++) step(0,0,0, 32'h100, 1,1,32'h100, 0,0);
    step(0,0,0, 32'h100, 0,0,32'h0, 0,0);

    // Predicted taken, actually not taken, while fetch is stalled
    step(0,0,1, 32'h200, 1,1,32'h200, 0,1);
    for (int i = 0; i < 4; i++) step(0,0,1, 32'h200, 0,0,32'h0, 0,0);
    step(0,0,0, 32'h200, 0,0,32'h0, 0,0);
    step(0,0,0, 32'h200, 0,0,32'h0, 0,0);

    // Mispredict 01 under hazard stall, then unstalled
    step(1,0,1, 32'h100, 1,1,32'h100, 1,0);
    step(0,0,1, 32'h100, 1,1,32'h100, 1,0);
    // csr_stall holds PENDING despite if_stall low
    step(0,1,0, 32'h100, 0,0,32'h0, 0,0);
    // Overwrite kind while still pending
    step(0,0,1, 32'h100, 1,1,32'h300, 0,1);
    step(0,0,1, 32'h100, 0,0,32'h0, 0,0);

    // Asynchronous reset mid-PENDING
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flush_pending", bus.flush_pending, 0);
    chk("async_rst_pending_kind", bus.pending_kind, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive_idle();
    step(0,0,0, 32'h100, 0,0,32'h0, 0,0);

    // Aliasing: 0x140 and 0x100 share a slot
    step(0,0,0, 32'h100, 1,1,32'h140, 1,1);
    step(0,0,0, 32'h100, 0,0,32'h0, 0,0);
    // Five unstalled mispredicts
    for (int i = 0; i < 5; i++) step(0,0,0, 32'h100, 1,1,32'h180, 1,0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0,5) == 0, $urandom_range(0,7) == 0,
           $urandom_range(0,1) == 1, 32'($urandom_range(0,63) * 4),
           $urandom_range(0,3) != 0, $urandom_range(0,3) != 0,
           32'($urandom_range(0,63) * 4),
           $urandom_range(0,1) == 1, $urandom_range(0,1) == 1);
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
